sb_prefetch_ctrl: RTL and testbench
===================================

// Module: sb_prefetch_ctrl
// PURPOSE
//  Next-line prefetch controller directly upstream of stream_buffer.
//  Takes cache refill (miss) requests, answers hit/miss from the line held in
//  the stream buffer, then launches a prefetch of miss_label+1.
//  Drives stream_buffer label_i/label_i_rdy and consumes its label_o/data/data_vld.
//  One stream buffer, one outstanding prefetch.
// PARAMETERS
//  LINE_WIDTH   256  cache line bits; must match stream_buffer.LINE_WIDTH
//  PAGE_BITS    12   log2 page bytes; prefetch never crosses a page
//  LINE_BYTE_OFFSET (local) = $clog2(LINE_WIDTH/8)
//  LABEL_WIDTH  (local) = $bits(phys_t) - LINE_BYTE_OFFSET
// PORTS
//  clk           in   1            clock
//  rst           in   1            reset, synchronous, active-high
//  pf_en         in   1            prefetch enable; 0 = never issue, always answer miss
//  flush         in   1            invalidate held/in-flight line and queued prefetch
//  miss_req      in   1            refill request; held high until miss_ack
//  miss_label    in   LABEL_WIDTH  requested line label (tag+index); stable while miss_req
//  miss_ack      out  1            1-cycle pulse, completes the request
//  miss_hit      out  1            valid with miss_ack: 1 = miss_line holds the line
//  miss_line     out  LINE_WIDTH   line data, valid with miss_ack && miss_hit
//  sb_label      out  LABEL_WIDTH  to stream_buffer.label_i
//  sb_label_rdy  out  1            to stream_buffer.label_i_rdy, 1-cycle pulse
//  sb_label_o    in   LABEL_WIDTH  from stream_buffer.label_o
//  sb_data       in   LINE_WIDTH   from stream_buffer.data
//  sb_data_vld   in   1            from stream_buffer.data_vld
// BEHAVIOUR
//  Reset: state=S_IDLE; miss_ack/miss_hit/sb_label_rdy=0; miss_line, sb_label=0;
//   pending=0, stale=1, q_vld=0. stream_buffer shares rst.
//  Internal regs: pending (prefetch in flight), inflight_label, stale (held line unusable),
//   q_vld/q_label (one-entry queued prefetch; a new entry overwrites an older one).
//  line_ok = sb_data_vld & ~pending & ~stale.
//  FSM:
//   S_IDLE: on miss_req:
//    - line_ok & sb_label_o==miss_label -> S_RESP, hit=1, miss_line<=sb_data.
//    - pending & ~stale & inflight_label==miss_label -> S_WAIT_FILL.
//    - else -> S_RESP, hit=0.
//   S_RESP: miss_ack=1 for exactly one cycle with registered hit/line -> S_IDLE.
//    Same cycle: if pf_en and miss_label+1 does not cross a page, q_label<=miss_label+1, q_vld<=1.
//    Page cross = low (PAGE_BITS-LINE_BYTE_OFFSET) bits of miss_label all ones.
//    Also suppresses wrap at all-ones label.
//   S_WAIT_FILL: when pending clears via fill -> S_RESP with hit=1, miss_line<=sb_data.
//    If flush arrives first -> S_RESP with hit=0.
//  Latency: request to miss_ack = 2 cycles (S_IDLE decision + S_RESP).
//   Wait-fill: miss_ack 2 cycles after first sb_data_vld high.
//  Issue: sb_label_rdy=1, sb_label=q_label when q_vld & ~pending & state!=S_WAIT_FILL.
//   Next edge: pending<=1, inflight_label<=q_label, q_vld<=0, stale<=0.
//  Fill: pending & sb_data_vld -> pending<=0 next edge. sb_data_vld is low the cycle after issue.
//   So an issue can never see a stale completion.
//  Stream buffer accepts label_i_rdy only in IDLE/FINISH. ~pending guarantees this.
//   Never pulse sb_label_rdy while pending.
//  flush: q_vld<=0, stale<=1; pending still tracks the in-flight burst to completion.
//   flush wins over a same-cycle issue (no pulse).
//  pf_en=0: q_vld forced 0; hits on an already-held line are still reported.
//  Simultaneous issue and miss_req decision are allowed. The lookup uses pre-edge pending/line_ok.
// TESTING
//  T1 reset; miss_req label=0x100 -> ack hit=0 at cycle+2; next cycle sb_label_rdy pulse, sb_label=0x101.
//  T2 bench SB model fills 0x101 (data=pattern A); miss_req 0x101 -> ack hit=1, miss_line=A; then prefetch 0x102 issued.
//  T3 miss_req 0x102 while 0x102 in flight -> no ack until fill; ack hit=1 2 cycles after sb_data_vld rises.
//  T4 miss_req 0x17F (page end) -> ack hit=0, no sb_label_rdy; label all-ones likewise.
//  T5 pending 0x201; misses 0x300 then 0x400 -> after fill exactly one pulse, sb_label=0x401.
//  T6 flush with 0x101 held -> miss_req 0x101 acks hit=0; rst asserted in S_WAIT_FILL -> all outputs 0, next request served normally.

Source files
------------

// File: rtl/sb_prefetch_ctrl_if.sv
// Bundle of the refill-request side and the stream_buffer side of sb_prefetch_ctrl.
// The master modport is the environment; the slave modport is the controller.
interface sb_prefetch_ctrl_if #(
    parameter int LINE_WIDTH = 256,
    parameter int PHYS_WIDTH = 32
);
    localparam int LABEL_WIDTH = PHYS_WIDTH - $clog2(LINE_WIDTH / 8);

    logic                   pf_en;
    logic                   flush;
    logic                   miss_req;
    logic [LABEL_WIDTH-1:0] miss_label;
    logic                   miss_ack;
    logic                   miss_hit;
    logic [LINE_WIDTH-1:0]  miss_line;
    logic [LABEL_WIDTH-1:0] sb_label;
    logic                   sb_label_rdy;
    logic [LABEL_WIDTH-1:0] sb_label_o;
    logic [LINE_WIDTH-1:0]  sb_data;
    logic                   sb_data_vld;

    modport master (
        output pf_en, flush, miss_req, miss_label, sb_label_o, sb_data, sb_data_vld,
        input  miss_ack, miss_hit, miss_line, sb_label, sb_label_rdy
    );

    modport slave (
        input  pf_en, flush, miss_req, miss_label, sb_label_o, sb_data, sb_data_vld,
        output miss_ack, miss_hit, miss_line, sb_label, sb_label_rdy
    );
endinterface

// File: rtl/sb_prefetch_ctrl.sv
// Next-line prefetch controller in front of a single stream_buffer: answers refill
// requests from the held line, then queues a prefetch of the following line in the page.
module sb_prefetch_ctrl #(
    parameter int LINE_WIDTH = 256,
    parameter int PAGE_BITS  = 12,
    parameter int PHYS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    sb_prefetch_ctrl_if.slave    bus
);
    typedef logic [PHYS_WIDTH-1:0] phys_t;

    localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int LABEL_WIDTH      = $bits(phys_t) - LINE_BYTE_OFFSET;
    localparam int PAGE_LINE_BITS   = PAGE_BITS - LINE_BYTE_OFFSET;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RESP      = 2'd1;
    localparam logic [1:0] S_WAIT_FILL = 2'd2;

    logic [1:0]             state;
    logic                   hit_q;
    logic [LINE_WIDTH-1:0]  line_q;
    logic [LABEL_WIDTH-1:0] req_label;
    logic                   pending;
    logic [LABEL_WIDTH-1:0] inflight_label;
    logic                   stale;
    logic                   q_vld;
    logic [LABEL_WIDTH-1:0] q_label;

    logic                   line_ok;
    logic                   issue;
    logic                   page_end;
    logic                   enqueue;
    logic [LABEL_WIDTH-1:0] next_label;

    assign line_ok    = bus.sb_data_vld & ~pending & ~stale;
    assign issue      = q_vld & ~pending & (state != S_WAIT_FILL) & ~bus.flush;
    // Last line of a page (this also covers the all-ones label, so +1 never wraps).
    assign page_end   = &req_label[PAGE_LINE_BITS-1:0];
    assign next_label = req_label + 1'b1;
    assign enqueue    = (state == S_RESP) & bus.pf_en & ~page_end;

    assign bus.miss_ack     = (state == S_RESP);
    assign bus.miss_hit     = hit_q;
    assign bus.miss_line    = line_q;
    assign bus.sb_label_rdy = issue;
    assign bus.sb_label     = issue ? q_label : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            hit_q          <= 1'b0;
            line_q         <= '0;
            req_label      <= '0;
            pending        <= 1'b0;
            inflight_label <= '0;
            stale          <= 1'b1;
            q_vld          <= 1'b0;
            q_label        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.miss_req) begin
                        req_label <= bus.miss_label;
                        if (line_ok && bus.sb_label_o == bus.miss_label) begin
                            state  <= S_RESP;
                            hit_q  <= 1'b1;
                            line_q <= bus.sb_data;
                        end else if (pending && !stale && inflight_label == bus.miss_label) begin
                            state <= S_WAIT_FILL;
                        end else begin
                            state <= S_RESP;
                            hit_q <= 1'b0;
                        end
                    end
                end
                S_RESP: state <= S_IDLE;
                S_WAIT_FILL: begin
                    // A fill that landed on the entry edge leaves pending low with the line held.
                    if (bus.flush) begin
                        state <= S_RESP;
                        hit_q <= 1'b0;
                    end else if (bus.sb_data_vld && (pending || bus.sb_label_o == req_label)) begin
                        state  <= S_RESP;
                        hit_q  <= 1'b1;
                        line_q <= bus.sb_data;
                    end else if (!pending) begin
                        state <= S_RESP;
                        hit_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // NOTE: non-blocking updates below are ordered by priority; the last one to fire wins.
            if (pending && bus.sb_data_vld) pending <= 1'b0;
            if (issue) begin
                pending        <= 1'b1;
                inflight_label <= q_label;
                q_vld          <= 1'b0;
                stale          <= 1'b0;
            end
            if (enqueue) begin
                q_label <= next_label;
                q_vld   <= 1'b1;
            end
            if (bus.flush) begin
                q_vld <= 1'b0;
                stale <= 1'b1;
            end
            if (!bus.pf_en) q_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sb_prefetch_ctrl.sv
// Directed bench for sb_prefetch_ctrl with a small behavioural stream_buffer model.
module tb_sb_prefetch_ctrl;
    localparam int LINE = 256;
    localparam int LW   = 27;

    logic clk;
    logic rst;

    sb_prefetch_ctrl_if #(.LINE_WIDTH(LINE), .PHYS_WIDTH(32)) bus ();

    sb_prefetch_ctrl #(.LINE_WIDTH(LINE), .PAGE_BITS(12), .PHYS_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [LINE-1:0] got, input logic [LINE-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE-1:0] pat(input logic [LW-1:0] l);
        return {8{32'hA500_0000 ^ {5'b0, l}}};
    endfunction

    // Stream buffer model: drives one time unit after the edge, bench samples at two.
    int            fill_delay = 2;
    bit            fill_hold  = 1'b0;
    int            m_cnt      = 0;
    bit            m_busy     = 1'b0;
    logic [LW-1:0] m_lbl      = '0;
    logic          m_iss;
    logic [LW-1:0] m_in;
    logic          m_rst;

    always @(posedge clk) begin
        m_iss = bus.sb_label_rdy;
        m_in  = bus.sb_label;
        m_rst = rst;
        #1;
        if (m_rst) begin
            bus.sb_data_vld = 1'b0;
            bus.sb_label_o  = '0;
            bus.sb_data     = '0;
            m_busy          = 1'b0;
            m_cnt           = 0;
        end else if (m_iss) begin
            bus.sb_data_vld = 1'b0;
            m_busy          = 1'b1;
            m_cnt           = fill_delay;
            m_lbl           = m_in;
        end else if (m_busy && !fill_hold) begin
            if (m_cnt <= 1) begin
                m_busy          = 1'b0;
                bus.sb_data_vld = 1'b1;
                bus.sb_label_o  = m_lbl;
                bus.sb_data     = pat(m_lbl);
            end else begin
                m_cnt--;
            end
        end
    end

    int            pulse_cnt = 0;
    logic [LW-1:0] last_lbl  = '0;

    always @(negedge clk) begin
        if (bus.sb_label_rdy) begin
            pulse_cnt++;
            last_lbl = bus.sb_label;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [LW-1:0] lbl, output int lat, output int vld_at,
                       output logic hit, output logic [LINE-1:0] line);
        bus.miss_label = lbl;
        bus.miss_req   = 1'b1;
        lat    = -1;
        vld_at = -1;
        hit    = 1'b0;
        line   = '0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.sb_data_vld && vld_at < 0) vld_at = i;
            if (bus.miss_ack) begin
                lat  = i;
                hit  = bus.miss_hit;
                line = bus.miss_line;
                break;
            end
        end
        bus.miss_req = 1'b0;
    endtask

    task automatic wait_fill(input string tag);
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.sb_data_vld) break;
        end
        check(tag, bus.sb_data_vld, 1'b1);
        step();
    endtask

    task automatic expect_issue(input string tag, input logic [LW-1:0] lbl);
        check({tag, "_rdy"}, bus.sb_label_rdy, 1'b1);
        check({tag, "_label"}, bus.sb_label, lbl);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"},   bus.miss_ack, 1'b0);
        check({tag, "_hit"},   bus.miss_hit, 1'b0);
        check({tag, "_line"},  bus.miss_line, '0);
        check({tag, "_rdy"},   bus.sb_label_rdy, 1'b0);
        check({tag, "_label"}, bus.sb_label, '0);
    endtask

    int              lat;
    int              vld_at;
    int              acks;
    logic            hit;
    logic [LINE-1:0] line;

    initial begin
        rst            = 1'b1;
        bus.pf_en      = 1'b1;
        bus.flush      = 1'b0;
        bus.miss_req   = 1'b0;
        bus.miss_label = '0;
        repeat (3) step();
        check_idle_outputs("t1_reset");
        rst = 1'b0;
        step();

        // T1: cold miss, then next-line prefetch
        req(27'h100, lat, vld_at, hit, line);
        check("t1_lat", lat, 1);
        check("t1_hit", hit, 1'b0);
        step();
        expect_issue("t1_pf", 27'h101);

        // T2: hit on the prefetched line
        wait_fill("t2_fill");
        req(27'h101, lat, vld_at, hit, line);
        check("t2_lat", lat, 1);
        check("t2_hit", hit, 1'b1);
        check("t2_line", line, pat(27'h101));
        step();
        expect_issue("t2_pf", 27'h102);

        // T3: request for the line in flight waits for the fill
        fill_delay = 4;
        step();
        req(27'h102, lat, vld_at, hit, line);
        check("t3_vld_at", vld_at, 4);
        check("t3_lat", lat, 5);
        check("t3_hit", hit, 1'b1);
        check("t3_line", line, pat(27'h102));
        fill_delay = 2;
        step();
        expect_issue("t3_pf", 27'h103);

        // T4: page end and all-ones labels never prefetch
        wait_fill("t4_fill");
        pulse_cnt = 0;
        req(27'h17F, lat, vld_at, hit, line);
        check("t4_page_lat", lat, 1);
        check("t4_page_hit", hit, 1'b0);
        repeat (3) step();
        req(27'h7FF_FFFF, lat, vld_at, hit, line);
        check("t4_ones_lat", lat, 1);
        check("t4_ones_hit", hit, 1'b0);
        repeat (3) step();
        check("t4_no_pulse", pulse_cnt, 0);

        // T5: queued prefetch is overwritten while one is pending
        req(27'h200, lat, vld_at, hit, line);
        check("t5_200_hit", hit, 1'b0);
        fill_hold = 1'b1;
        step();
        expect_issue("t5_pf", 27'h201);
        step();
        pulse_cnt = 0;
        req(27'h300, lat, vld_at, hit, line);
        check("t5_300_lat", lat, 1);
        check("t5_300_hit", hit, 1'b0);
        step();
        req(27'h400, lat, vld_at, hit, line);
        check("t5_400_lat", lat, 1);
        check("t5_400_hit", hit, 1'b0);
        step();
        check("t5_held_no_pulse", pulse_cnt, 0);
        fill_hold = 1'b0;
        repeat (10) step();
        check("t5_pulses", pulse_cnt, 1);
        check("t5_label", last_lbl, 27'h401);

        // T6a: flush beats a same-cycle issue
        req(27'h100, lat, vld_at, hit, line);
        check("t6_100_hit", hit, 1'b0);
        step();
        expect_issue("t6_pre_flush", 27'h101);
        pulse_cnt = 0;
        bus.flush = 1'b1;
        #1;
        check("t6_flush_rdy", bus.sb_label_rdy, 1'b0);
        step();
        bus.flush = 1'b0;
        repeat (3) step();
        check("t6_flush_no_pulse", pulse_cnt, 0);

        // T6b: flush makes the held line unusable
        req(27'h100, lat, vld_at, hit, line);
        check("t6_again_hit", hit, 1'b0);
        step();
        expect_issue("t6_pf", 27'h101);
        wait_fill("t6_fill");
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        req(27'h101, lat, vld_at, hit, line);
        check("t6_stale_lat", lat, 1);
        check("t6_stale_hit", hit, 1'b0);
        step();
        expect_issue("t6_pf2", 27'h102);

        // T6c: reset while waiting for a fill
        fill_hold = 1'b1;
        step();
        bus.miss_label = 27'h102;
        bus.miss_req   = 1'b1;
        acks = 0;
        repeat (3) begin
            step();
            if (bus.miss_ack) acks++;
        end
        check("t6_wait_noack", acks, 0);
        rst          = 1'b1;
        bus.miss_req = 1'b0;
        fill_hold    = 1'b0;
        step();
        check_idle_outputs("t6_rst");
        step();
        rst = 1'b0;
        step();
        req(27'h100, lat, vld_at, hit, line);
        check("t6_post_lat", lat, 1);
        check("t6_post_hit", hit, 1'b0);
        step();
        expect_issue("t6_post_pf", 27'h101);

        // pf_en=0: held line still hits, nothing is prefetched
        wait_fill("pfoff_fill");
        bus.pf_en = 1'b0;
        pulse_cnt = 0;
        req(27'h101, lat, vld_at, hit, line);
        check("pfoff_lat", lat, 1);
        check("pfoff_hit", hit, 1'b1);
        check("pfoff_line", line, pat(27'h101));
        repeat (4) step();
        check("pfoff_no_pulse", pulse_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
